// File: rtl/mul_accum_pkg.sv
// rtl/mul_accum_pkg.sv - shared widths, counter sizing and saturation helper for mul_accum_reduce
package mul_accum_pkg;

  localparam int DEF_MUL_LAT  = 4;
  localparam int DEF_REDUCE_N = 4;
  localparam int DEF_IN_W     = 16;
  localparam int DEF_ACC_W    = 24;

  // A one-product group still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W = cnt_width(DEF_REDUCE_N);

  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                  input int w,
                                                  output logic clipped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    clipped = 1'b0;
    if (v > hi) begin
      clipped = 1'b1;
      return hi;
    end
    if (v < lo) begin
      clipped = 1'b1;
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - enable-gated shift register that tags a pipelined datapath with its valid bit
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge CLK) begin
    if (rst) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/mul_accum_reduce.sv
// rtl/mul_accum_reduce.sv - sums every REDUCE_N valid multiplier products into one registered result
// Optional saturating accumulation when MUL_ACCUM_SAT_EN is defined; wraps otherwise.
module mul_accum_reduce
  import mul_accum_pkg::*;
#(
  parameter int MUL_LAT  = DEF_MUL_LAT,
  parameter int REDUCE_N = DEF_REDUCE_N,
  parameter int IN_W     = DEF_IN_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    src_valid,
  input  logic signed [IN_W-1:0]  p,
  output logic                    up_ce,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int CW = cnt_width(REDUCE_N);
  localparam int SW = ACC_W + 1;
  localparam logic [CW-1:0] LAST = CW'(REDUCE_N - 1);

  logic                    in_valid;
  logic [CW-1:0]           cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] base;
  logic signed [SW-1:0]    sum_wide;
  logic signed [ACC_W-1:0] sum_next;

  // Reset must not be blocked by a pending unaccepted result.
  assign up_ce = ce & (rst | ~(out_valid & ~out_ready));

  valid_delay_line #(
    .DEPTH(MUL_LAT)
  ) u_valid_dly (
    .CLK (CLK),
    .rst (rst),
    .en  (up_ce),
    .din (src_valid),
    .dout(in_valid)
  );

`ifdef MUL_ACCUM_SAT_EN
  logic                 clip;
  logic                 grp_sat;
  logic                 sat_next;
  logic                 sat_q;
  logic signed [63:0]   clipped;

  always_comb begin
    clip     = 1'b0;
    base     = (cnt == '0) ? '0 : acc;
    sum_wide = SW'(base) + SW'(p);
    clipped  = sat_clip(64'(sum_wide), ACC_W, clip);
    sum_next = clipped[ACC_W-1:0];
    sat_next = ((cnt == '0) ? 1'b0 : grp_sat) | clip;
  end

  assign out_sat = sat_q;
`else
  always_comb begin
    base     = (cnt == '0) ? '0 : acc;
    sum_wide = SW'(base) + SW'(p);
    sum_next = sum_wide[ACC_W-1:0];
  end

  assign out_sat = 1'b0;
`endif

  // up_ce high implies no stall, so a pending result here is always being accepted.
  always_ff @(posedge CLK) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef MUL_ACCUM_SAT_EN
      grp_sat   <= 1'b0;
      sat_q     <= 1'b0;
`endif
    end else if (up_ce) begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid) begin
        if (cnt == LAST) begin
          out_data  <= sum_next;
          out_valid <= 1'b1;
          cnt       <= '0;
`ifdef MUL_ACCUM_SAT_EN
          sat_q     <= sat_next;
`endif
        end else begin
          acc <= sum_next;
          cnt <= cnt + 1'b1;
`ifdef MUL_ACCUM_SAT_EN
          grp_sat <= sat_next;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_accum_reduce.sv
// tb/tb_mul_accum_reduce.sv - scoreboard bench for mul_accum_reduce (ACC_W 24 and 16 instances)
module tb_mul_accum_reduce;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic               rst, ce, src_valid, out_ready;
  logic signed [15:0] prod, p;
  logic               up_ce, out_valid, out_sat;
  logic signed [23:0] out_data;
  logic               up_ce16, out_valid16, out_sat16;
  logic signed [15:0] out_data16;

  int checks   = 0;
  int failures = 0;
  bit g1_done  = 1'b0;

  typedef struct {
    longint d;
    bit     s;
  } exp_t;

  exp_t q[$];
  exp_t q16[$];

  logic signed [15:0] mpipe [4];

  mul_accum_reduce #(.MUL_LAT(4), .REDUCE_N(4), .IN_W(16), .ACC_W(24)) dut (
    .CLK(CLK), .rst(rst), .ce(ce), .src_valid(src_valid), .p(p), .up_ce(up_ce),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  mul_accum_reduce #(.MUL_LAT(4), .REDUCE_N(4), .IN_W(16), .ACC_W(16)) dut16 (
    .CLK(CLK), .rst(rst), .ce(ce), .src_valid(src_valid), .p(p), .up_ce(up_ce16),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .out_sat(out_sat16)
  );

  // Behavioural 4-stage multiplier; the product is supplied directly and frozen by up_ce.
  always @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mpipe[i] <= '0;
    end else if (up_ce) begin
      mpipe[0] <= prod;
      for (int i = 1; i < 4; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign p = mpipe[3];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input longint d, input bit s, input longint d16, input bit s16);
    exp_t e;
    e.d = d;   e.s = s;   q.push_back(e);
    e.d = d16; e.s = s16; q16.push_back(e);
  endtask

  task automatic beat(input bit v, input int val);
    @(negedge CLK);
    src_valid = v;
    prod = 16'(val);
    #1;
    for (int k = 0; !up_ce; k++) begin
      if (k > 50) begin
        chk("up_ce_timeout", 0, 1);
        break;
      end
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (out_valid && out_ready && ce && !rst) begin
        if (q.size() == 0) chk("unexpected_out", out_data, 0);
        else begin
          e = q.pop_front();
          chk("sum", out_data, e.d);
          chk("sat", out_sat, e.s);
        end
      end
      if (out_valid16 && out_ready && ce && !rst) begin
        if (q16.size() == 0) chk("unexpected_out16", out_data16, 0);
        else begin
          e = q16.pop_front();
          chk("sum16", out_data16, e.d);
          chk("sat16", out_sat16, e.s);
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int k;
    rst = 1'b1; ce = 1'b1; src_valid = 1'b0; prod = '0; out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_up_ce", up_ce, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    @(negedge CLK);
    rst = 1'b0;
    out_ready = 1'b0;

    // Latency, stall hold and back-to-back group with products in flight.
    push(114, 0, 114, 0);
    push(4, 0, 4, 0);
    fork
      begin
        beat(1, 15); beat(1, -8); beat(1, 100); beat(1, 7);
        g1_done = 1'b1;
        beat(1, 1); beat(1, 1); beat(1, 1); beat(1, 1);
        beat(0, 0);
      end
      begin
        wait (g1_done);
        for (k = 1; k <= 10; k++) begin
          @(negedge CLK);
          #1;
          if (out_valid) break;
        end
        chk("latency", k, 5);
        for (int i = 0; i < 3; i++) begin
          if (i > 0) begin
            @(negedge CLK);
            #1;
          end
          chk("stall_up_ce", up_ce, 0);
          chk("stall_up_ce16", up_ce16, 0);
          chk("stall_data", out_data, 114);
        end
        @(negedge CLK);
        out_ready = 1'b1;
      end
    join
    idle(8);

    // Bubbles between valid beats.
    push(14, 0, 14, 0);
    beat(1, 2); beat(0, 0); beat(0, 0); beat(1, 3); beat(1, 4); beat(0, 0); beat(1, 5);
    idle(8);

    // Overflow of the 16-bit accumulator.
`ifdef MUL_ACCUM_SAT_EN
    push(131068, 0, 32767, 1);
`else
    push(131068, 0, -4, 0);
`endif
    repeat (4) beat(1, 32767);
    idle(8);

    // Reset mid-group discards the partial sum.
    beat(1, 50); beat(1, 60);
    idle(6);
    @(negedge CLK);
    rst = 1'b1;
    src_valid = 1'b0;
    #1;
    chk("mid_rst_up_ce", up_ce, 1);
    @(negedge CLK);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    push(100, 0, 100, 0);
    beat(1, 10); beat(1, 20); beat(1, 30); beat(1, 40);
    idle(8);

    // ce low mid-group with junk on the source side.
    push(10, 0, 10, 0);
    beat(1, 1); beat(1, 2);
    @(negedge CLK);
    ce = 1'b0;
    src_valid = 1'b1;
    prod = 16'sd99;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      chk("ce_low_up_ce", up_ce, 0);
      chk("ce_low_out_valid", out_valid, 0);
    end
    @(negedge CLK);
    ce = 1'b1;
    src_valid = 1'b0;
    beat(1, 3); beat(1, 4);
    idle(10);

    chk("queue_empty", q.size(), 0);
    chk("queue16_empty", q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_accum_reduce.md
# mul_accum_reduce

Downstream consumer of the pipelined signed 8x8 multiplier: it sums every REDUCE_N consecutive valid 16-bit products into one signed ACC_W-bit result. It sits directly on the multiplier's p output and carries the valid tag through a delay line matched to the multiplier latency. It generates the multiplier's clock enable, so back-pressure from the consumer freezes the whole multiplier pipeline.

## Interface
- MUL_LAT, 4: multiplier latency in cycles, from a/b launch to p; legal range 1..8.
- REDUCE_N, 4: products per output sum; legal range 1..256.
- IN_W, 16: product width.
- ACC_W, 24: accumulator and output width; must satisfy ACC_W >= IN_W.
- CLK  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  global enable from the system.
- src_valid  in  1  high in the cycle a/b are presented to the multiplier.
- p  in  IN_W  signed product from the multiplier.
- up_ce  out  1  drives the multiplier's ce.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  signed sum.
- out_sat  out  1  sum was clipped (see Configuration).

## Operation
- Stall condition: stall = out_valid & ~out_ready. Output up_ce = ce & ~stall (combinational).
- All internal state advances only when up_ce = 1. This includes the valid delay line, the accumulator and the beat counter.
- Valid delay line:
  - MUL_LAT-stage shift register of src_valid.
  - in_valid = last stage, aligned with p.
- Accumulate on each cycle with up_ce & in_valid:
  - sum_next = (cnt == 0 ? 0 : acc) + sign_extend(p).
  - If cnt < REDUCE_N-1: acc <= sum_next, cnt <= cnt+1.
  - If cnt == REDUCE_N-1: out_data <= sum_next, out_valid <= 1, cnt <= 0.
- Output handshake:
  - A transfer happens in a cycle with out_valid & out_ready.
  - On a transfer, out_valid clears unless a new sum loads in the same cycle. In that case out_valid stays 1 with the new data.
- While out_valid & ~out_ready: out_data and out_sat are held stable, and the upstream pipeline is frozen.
- Cycles with in_valid = 0 do not advance cnt; bubbles are allowed anywhere.
- REDUCE_N = 1: every valid product passes through, sign-extended.
- Reset:
  - All state is zeroed: acc, cnt, delay line, out_data, out_valid, out_sat.
  - A partial sum in progress is discarded.
  - During reset, up_ce = ce.
- ce = 0: nothing changes, and the output holds.

## Timing
- src_valid of the final beat of a group at cycle t gives out_valid at cycle t+MUL_LAT+1, provided there is no stall.
- Sustained throughput is one product per cycle, with no bubble between groups.
- Output is registered. The only combinational path is out_ready/ce to up_ce.

## Configuration
- MUL_ACCUM_SAT_EN defined:
  - Each addition saturates to the signed range of ACC_W.
  - out_sat is a sticky flag per group, set if any addition in the group clipped; it is presented alongside out_data.
- MUL_ACCUM_SAT_EN not defined:
  - Addition wraps modulo 2^ACC_W.
  - out_sat is tied to 0.

## Structure
- Shared package mul_accum_pkg holds:
  - the saturation helper function;
  - a constant CNT_W = clog2(REDUCE_N) with a minimum of 1;
  - the default widths.
- One sub-module, valid_delay_line: parameterised depth, synchronous reset, enable input. It is reusable for tagging other pipelined arithmetic stages.

## Test plan
The bench drives p from a behavioural MUL_LAT=4 multiplier model that honours up_ce.
- Products 15, -8, 100, 7 on consecutive cycles -> out_data = 114, out_valid rises 5 cycles after the last src_valid, out_sat = 0.
- Result held with out_ready low for 3 cycles -> up_ce low for those 3 cycles, out_data stable at 114; the next group of 1,1,1,1 yields 4 with no lost or duplicated beat.
- src_valid pattern 1,0,0,1,1,0,1 with products 2,3,4,5 -> a single output of 14, and cnt advances only on valid beats.
- ACC_W = 16 with four products of 32767 -> without the macro out_data = 16'hFFFC (-4), out_sat = 0; with MUL_ACCUM_SAT_EN out_data = 32767, out_sat = 1.
- rst pulsed after 2 of 4 beats, then 10, 20, 30, 40 -> out_data = 100; no residue from the discarded partial sum.
- ce low for 5 cycles mid-group -> all state frozen, up_ce = 0; the group completes with the correct sum after ce returns high.
